// File: rtl/rffp_pkg.sv
// Shared definitions for the RFFP accumulator: default widths, the unpacked
// product layout and the datapath FSM states.
package rffp_pkg;

    localparam int DEF_EXP_WIDTH  = 8;
    localparam int DEF_MAN_WIDTH  = 7;
    localparam int DEF_GUARD_BITS = 3;
    localparam int DEF_CNT_WIDTH  = 16;

    // Largest representable biased exponent.
    localparam int MAX_EXP  = (1 << DEF_EXP_WIDTH) - 1;
    // Unpacked product: {sign, exp, explicit-one mantissa}.
    localparam int IN_W     = DEF_EXP_WIDTH + DEF_MAN_WIDTH + 2;
    // Packed result: {sign, exp, mantissa without hidden bit}.
    localparam int PACKED_W = DEF_EXP_WIDTH + DEF_MAN_WIDTH + 1;
    // Internal accumulator mantissa: hidden bit + stored bits + guard bits.
    localparam int W        = DEF_MAN_WIDTH + 1 + DEF_GUARD_BITS;

    typedef struct packed {
        logic                     sign;
        logic [DEF_EXP_WIDTH-1:0] exp;
        logic [DEF_MAN_WIDTH:0]   mant;
    } rffp_unpacked_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } state_t;

endpackage

// File: rtl/rffp_accumulator_if.sv
// Product-in / result-out bus of the RFFP accumulator.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload (data, last) stable until that edge;
// ready may depend on state only, never on valid. out_data/out_count stay
// stable while out_valid is high and out_ready is low.
interface rffp_accumulator_if #(
    parameter int IN_W     = 17,
    parameter int PACKED_W = 16,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [PACKED_W-1:0] out_data;
    logic [CNT_W-1:0]    out_count;

    // Producer of products and consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/rffp_lzc.sv
// Parameterized leading-zero counter; an all-zero input yields WIDTH.
module rffp_lzc #(
    parameter int WIDTH = 11,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);
    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end
endmodule

// File: rtl/rffp_accumulator.sv
// Streaming RFFP dot-product accumulator. Each product walks through
// ALIGN -> ADD -> NORM; the vector's final term then presents a rounded,
// packed result in OUT until the consumer takes it.
module rffp_accumulator
    import rffp_pkg::*;
#(
    parameter int RFFP_EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int RFFP_MAN_WIDTH = DEF_MAN_WIDTH,
    parameter int GUARD_BITS     = DEF_GUARD_BITS,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    rffp_accumulator_if.slave bus,
    output state_t            dbg_state
);
    localparam int EXP_W  = RFFP_EXP_WIDTH;
    localparam int MAN_W  = RFFP_MAN_WIDTH;
    localparam int ACC_W  = MAN_W + 1 + GUARD_BITS;
    localparam int EXT_W  = EXP_W + 2;
    localparam int LZ_W   = $clog2(ACC_W + 1);
    localparam int DIN_W  = EXP_W + MAN_W + 2;
    localparam int DOUT_W = EXP_W + MAN_W + 1;
    localparam logic [EXP_W-1:0] MAX_E = '1;

    state_t state, state_next;

    // Accumulator, kept normalized (bit ACC_W-1 set) or exactly +0.
    logic               acc_sign;
    logic [EXP_W-1:0]   acc_exp;
    logic [ACC_W-1:0]   acc_mant;
    // Captured operand.
    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [ACC_W-1:0]   op_mant;
    logic               op_last;
    // Aligned pair (a = accumulator side, b = operand side).
    logic               a_sign, b_sign;
    logic [ACC_W-1:0]   a_mant, b_mant;
    logic [EXP_W-1:0]   res_exp;
    // Raw sum including carry-out bit.
    logic               sum_sign;
    logic [ACC_W:0]     sum_mant;
    logic [CNT_WIDTH-1:0] count;

    logic               acc_big;
    logic [EXP_W-1:0]   exp_diff;
    logic [ACC_W-1:0]   acc_shift, op_shift;
    logic               add_sign;
    logic [ACC_W:0]     add_mant;
    logic [LZ_W-1:0]    lz;
    logic [EXT_W-1:0]   norm_exp_x;
    logic [ACC_W-1:0]   norm_mant_x;
    logic               norm_sign;
    logic [EXP_W-1:0]   norm_exp;
    logic [ACC_W-1:0]   norm_mant;
    logic [MAN_W+1:0]   rnd_mant;
    logic [EXP_W:0]     rnd_exp;
    logic [DOUT_W-1:0]  rnd_data;

    rffp_lzc #(.WIDTH(ACC_W)) u_lzc (
        .value(sum_mant[ACC_W-1:0]),
        .count(lz)
    );

    assign dbg_state     = state;
    assign bus.out_count = count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; clear forces IDLE from anywhere.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = ALIGN;
            end
            ALIGN: state_next = ADD;
            ADD:   state_next = NORM;
            NORM:  state_next = op_last ? OUT : IDLE;
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = rnd_data;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    // Align: shift the smaller-exponent mantissa right; too far means zero.
    always_comb begin
        acc_big   = (acc_exp >= op_exp);
        exp_diff  = acc_big ? (acc_exp - op_exp) : (op_exp - acc_exp);
        acc_shift = acc_mant;
        op_shift  = op_mant;
        if (acc_big) begin
            op_shift = (exp_diff >= EXP_W'(ACC_W)) ? '0 : (op_mant >> exp_diff);
        end else begin
            acc_shift = (exp_diff >= EXP_W'(ACC_W)) ? '0 : (acc_mant >> exp_diff);
        end
    end

    // Add/subtract magnitudes; the larger magnitude supplies the sign.
    always_comb begin
        add_sign = a_sign;
        add_mant = '0;
        if (a_sign == b_sign) begin
            add_mant = {1'b0, a_mant} + {1'b0, b_mant};
        end else if (a_mant >= b_mant) begin
            add_mant = {1'b0, a_mant - b_mant};
        end else begin
            add_mant = {1'b0, b_mant - a_mant};
            add_sign = b_sign;
        end
    end

    // Normalize the sum, flushing underflow/zero to +0 and saturating overflow.
    always_comb begin
        norm_mant_x = sum_mant[ACC_W-1:0] << lz;
        norm_exp_x  = {2'b00, res_exp} - EXT_W'(lz);
        if (sum_mant[ACC_W]) begin
            norm_mant_x = sum_mant[ACC_W:1];
            norm_exp_x  = {2'b00, res_exp} + EXT_W'(1);
        end
        norm_sign = sum_sign;
        norm_exp  = norm_exp_x[EXP_W-1:0];
        norm_mant = norm_mant_x;
        if (sum_mant == '0 || norm_exp_x[EXT_W-1] || norm_exp_x == '0) begin
            norm_sign = 1'b0;
            norm_exp  = '0;
            norm_mant = '0;
        end else if (norm_exp_x > {2'b00, MAX_E}) begin
            norm_exp  = MAX_E;
            norm_mant = '1;
        end
    end

    // Round half-up on the top guard bit and repack without the hidden bit.
    always_comb begin
        rnd_mant = {1'b0, acc_mant[ACC_W-1:GUARD_BITS]}
                 + (MAN_W+2)'(acc_mant[GUARD_BITS-1]);
        rnd_exp  = {1'b0, acc_exp};
        if (rnd_mant[MAN_W+1]) begin
            rnd_mant = rnd_mant >> 1;
            rnd_exp  = rnd_exp + (EXP_W+1)'(1);
        end
        if (rnd_exp > {1'b0, MAX_E}) begin
            rnd_exp  = {1'b0, MAX_E};
            rnd_mant = '1;
        end
        rnd_data = {acc_sign, rnd_exp[EXP_W-1:0], rnd_mant[MAN_W-1:0]};
    end

    // Datapath registers advanced by the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sign <= 1'b0;
            acc_exp  <= '0;
            acc_mant <= '0;
            op_sign  <= 1'b0;
            op_exp   <= '0;
            op_mant  <= '0;
            op_last  <= 1'b0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            a_mant   <= '0;
            b_mant   <= '0;
            res_exp  <= '0;
            sum_sign <= 1'b0;
            sum_mant <= '0;
            count    <= '0;
        end else if (clear) begin
            acc_sign <= 1'b0;
            acc_exp  <= '0;
            acc_mant <= '0;
            op_last  <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_sign <= bus.in_data[DIN_W-1];
                        op_exp  <= bus.in_data[DIN_W-2 -: EXP_W];
                        op_mant <= (bus.in_data[DIN_W-2 -: EXP_W] == '0) ? '0 :
                                   {bus.in_data[MAN_W:0], {GUARD_BITS{1'b0}}};
                        op_last <= bus.in_last;
                        if (count != '1) count <= count + 1'b1;
                    end
                end
                ALIGN: begin
                    a_sign  <= acc_sign;
                    b_sign  <= op_sign;
                    a_mant  <= acc_shift;
                    b_mant  <= op_shift;
                    res_exp <= acc_big ? acc_exp : op_exp;
                end
                ADD: begin
                    sum_sign <= add_sign;
                    sum_mant <= add_mant;
                end
                NORM: begin
                    acc_sign <= norm_sign;
                    acc_exp  <= norm_exp;
                    acc_mant <= norm_mant;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc_sign <= 1'b0;
                        acc_exp  <= '0;
                        acc_mant <= '0;
                        count    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rffp_accumulator.md
Name: rffp_accumulator

Overview:
- Streaming RFFP accumulator placed directly downstream of the RFFP multiplier.
- Consumes a stream of products in the multiplier's unpacked output format, which is sign, exponent and explicit-leading-one mantissa.
- Sums one vector of products, delimited by in_last, and emits the dot-product result in packed RFFP format with an implicit leading one. This packed format can be fed back into a multiplier operand.
- Multi-cycle FSM datapath: align, add, normalize, round; valid/ready handshakes on input and output.

Parameters:
- RFFP_EXP_WIDTH, 8, exponent width.
- RFFP_MAN_WIDTH, 7, stored mantissa width, excluding the hidden bit.
- GUARD_BITS, 3, extra low-order bits kept in the internal accumulator mantissa.
- CNT_WIDTH, 16, width of the term counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous abort/zero of the accumulator.
- in_valid  in  1  product valid.
- in_ready  out  1  accumulator can accept a product.
- in_data  in  EXP+MAN+2  {sign, exp[EXP-1:0], mant[MAN:0]}; mant[MAN] is the explicit leading 1.
- in_last  in  1  product is the final term of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  EXP+MAN+1  packed {sign, exp, mant[MAN-1:0]}.
- out_count  out  CNT_WIDTH  number of terms summed; saturates at all-ones.

Behaviour:
- Reset (rst_n=0): state IDLE; in_ready=1; out_valid=0; out_data=0; out_count=0; accumulator is +0 (sign 0, exp 0, mant 0).
- Zero encoding: any operand with exp==0 is zero, regardless of mantissa.
- Internal mantissa width is W = MAN+1+GUARD_BITS. An input mantissa is placed as mant << GUARD_BITS.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture the operand and in_last, increment the counter, go to ALIGN.
  - ALIGN: compare exponents and right-shift the smaller operand's mantissa by the difference. If the difference is >= W, the smaller operand becomes 0. The result exponent is the larger exponent.
  - ADD: equal signs give a magnitude sum (W+1 bits). Opposite signs give larger minus smaller magnitude; the result sign is that of the larger magnitude.
  - NORM:
    - Carry-out: shift right 1, exp+1.
    - Otherwise: shift left by the leading-zero count, exp minus that count.
    - Zero mantissa, or exponent <= 0 after the left shift: flush to +0.
    - Exponent > MAX_EXP: saturate to exp=MAX_EXP, mantissa all ones.
    - Write the result to the accumulator. If the captured last flag is set go to OUT, else go to IDLE.
  - OUT:
    - out_valid=1, in_ready=0.
    - out_data = rounded accumulator. Round half-up on internal bit GUARD_BITS-1. A rounding carry shifts right and increments exp, saturating as above.
    - out_data and out_count are held stable until out_ready.
    - On handshake: accumulator becomes +0, counter becomes 0, go to IDLE.
- Latency: product accepted at cycle T → ALIGN at T+1, ADD at T+2, NORM at T+3 → IDLE (in_ready=1) or OUT (out_valid=1) at T+4. Throughput is one product per 4 cycles.
- clear: has priority over every state and over a simultaneous input handshake. Next cycle: IDLE, accumulator +0, counter 0, out_valid=0. An in-flight product is discarded.
- Exact cancellation gives +0, never -0.
- A single-term vector (in_last on the first product) outputs that operand repacked with the hidden bit dropped.
- rst_n asserted mid-operation: all state cleared immediately.

Decomposition:
- Package rffp_pkg: MAX_EXP = 2^EXP-1; width localparams (IN_W, PACKED_W, W); a typedef for an unpacked {sign, exp, mant} struct; the state enum {IDLE, ALIGN, ADD, NORM, OUT}.
- One sub-module: rffp_lzc, a parameterized leading-zero counter used in NORM.

Test Plan (EXP=8, MAN=7, GUARD=3):
1. Add 1.0 and 1.0: 0x07F80 then 0x07F80 with in_last → out_data=0x4000, out_count=2, out_valid 4 cycles after the last accept.
2. Cancellation: 0x07FC0 then 0x17FC0 (last) → out_data=0x0000; sign must not be 1.
3. Rounding: 0x07F80 then 0x07780 (1.0 + 2^-8, last) → out_data=0x3F81. Small operand: 0x07F80 then 0x06A80 (difference 21 ≥ W) → out_data=0x3F80.
4. Saturation: 0x0FEFF then 0x0FEFF (last) → out_data=0x7FFF.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT → out_data/out_count stable, in_ready=0. Release → one handshake, then IDLE with the accumulator at +0.
6. Clear during ADD, and rst_n asserted during NORM → next cycle in IDLE, out_valid=0. A following single-term 0x07F80 (last) → out_data=0x3F80, out_count=1.
